// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit:
// FSM states, instruction classes, opcodes, ALU ops and datapath mux selects.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CLS_OP     = 4'd0,
        CLS_OPIMM  = 4'd1,
        CLS_LUI    = 4'd2,
        CLS_AUIPC  = 4'd3,
        CLS_LOAD   = 4'd4,
        CLS_STORE  = 4'd5,
        CLS_BRANCH = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JALR   = 4'd8,
        CLS_ILL    = 4'd9
    } instr_cls_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [1:0] PC_SRC_PC4 = 2'd0;
    localparam logic [1:0] PC_SRC_ALU = 2'd1;
    localparam logic [1:0] PC_SRC_REL = 2'd2;

    localparam logic [1:0] ASRC_RS1  = 2'd0;
    localparam logic [1:0] ASRC_PC   = 2'd1;
    localparam logic [1:0] ASRC_ZERO = 2'd2;

    localparam logic [1:0] BSRC_RS2  = 2'd0;
    localparam logic [1:0] BSRC_IMM  = 2'd1;
    localparam logic [1:0] BSRC_FOUR = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // OP only accepts the base and alternate funct7 encodings (no M extension).
    function automatic instr_cls_t classify(input logic [6:0] opcode, input logic [6:0] funct7);
        instr_cls_t cls;
        cls = CLS_ILL;
        case (opcode)
            OPC_OP:     cls = ((funct7 == F7_BASE) || (funct7 == F7_ALT)) ? CLS_OP : CLS_ILL;
            OPC_OPIMM:  cls = CLS_OPIMM;
            OPC_LUI:    cls = CLS_LUI;
            OPC_AUIPC:  cls = CLS_AUIPC;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            default:    cls = CLS_ILL;
        endcase
        return cls;
    endfunction

    function automatic logic [3:0] funct3_to_alu(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_alu_dec.sv
// Combinational opcode/funct3/funct7 -> alu_op decoder, shared between
// the control FSM and datapath tests.
module ctrl_alu_dec
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 4
) (
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    output logic [ALU_OP_W-1:0] alu_op
);

    logic       alt_sel;
    logic [3:0] op_raw;

    // SUB exists only in OP; in OP-IMM the funct7 field is immediate bits,
    // so only the shift-right encoding may select the arithmetic variant.
    always_comb begin
        alt_sel = 1'b0;
        op_raw  = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                alt_sel = (funct7 == F7_ALT);
                op_raw  = funct3_to_alu(funct3, alt_sel);
            end
            OPC_OPIMM: begin
                alt_sel = (funct3 == 3'b101) && (funct7 == F7_ALT);
                op_raw  = funct3_to_alu(funct3, alt_sel);
            end
            OPC_BRANCH: op_raw = ALU_SUB;
            default:    op_raw = ALU_ADD;
        endcase
    end

    assign alu_op = ALU_OP_W'(op_raw);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control FSM (IF/ID/EX/MEM/WB) with memory-wait timeout fault.
// Optional performance counters enabled by defining CTRL_PERF_CNT_EN.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int ALU_OP_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic                br_cond,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                ir_write,
    output logic [1:0]          pc_src,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic [1:0]          wb_sel,
    output logic                fault
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]         cycle_cnt,
    output logic [31:0]         instret_cnt
`endif
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t              state_q, state_d;
    instr_cls_t          cls_q, cls_d;
    logic [7:0]          wait_q, wait_d;
    logic                fault_q, fault_d;
    logic [ALU_OP_W-1:0] dec_alu_op;

    ctrl_alu_dec #(
        .ALU_OP_W (ALU_OP_W)
    ) u_alu_dec (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .alu_op (dec_alu_op)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            cls_q   <= CLS_ILL;
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        wait_d  = wait_q;
        fault_d = fault_q;
        case (state_q)
            S_RST: state_d = S_IF;
            S_IF:  state_d = S_ID;
            S_ID: begin
                cls_d = classify(opcode, funct7);
                if (cls_d == CLS_ILL) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                case (cls_q)
                    CLS_BRANCH: state_d = S_IF;
                    CLS_LOAD, CLS_STORE: begin
                        state_d = S_MEM;
                        wait_d  = '0;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                // A ready in the final allowed cycle still completes the access.
                if (mem_ready) begin
                    state_d = (cls_q == CLS_LOAD) ? S_WB : S_IF;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: state_d = S_IF;
            S_HALT: begin
                state_d = S_HALT;
                fault_d = 1'b1;
            end
            default: begin
                state_d = S_HALT;
                fault_d = 1'b1;
            end
        endcase
    end

    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        pc_src    = PC_SRC_PC4;
        alu_src_a = ASRC_RS1;
        alu_src_b = BSRC_RS2;
        alu_op    = ALU_OP_W'(ALU_ADD);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        case (state_q)
            S_IF: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            S_EX: begin
                alu_op = dec_alu_op;
                case (cls_q)
                    CLS_OPIMM, CLS_LOAD, CLS_STORE: alu_src_b = BSRC_IMM;
                    CLS_JALR: begin
                        alu_src_b = BSRC_IMM;
                        pc_write  = 1'b1;
                        pc_src    = PC_SRC_ALU;
                    end
                    CLS_LUI: begin
                        alu_src_a = ASRC_ZERO;
                        alu_src_b = BSRC_IMM;
                    end
                    CLS_AUIPC: begin
                        alu_src_a = ASRC_PC;
                        alu_src_b = BSRC_IMM;
                    end
                    CLS_JAL: begin
                        alu_src_a = ASRC_PC;
                        alu_src_b = BSRC_IMM;
                        pc_write  = 1'b1;
                        pc_src    = PC_SRC_REL;
                    end
                    CLS_BRANCH: begin
                        pc_write = br_cond;
                        pc_src   = PC_SRC_REL;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_read  = (cls_q == CLS_LOAD);
                mem_write = (cls_q == CLS_STORE);
            end
            S_WB: begin
                reg_write = 1'b1;
                if ((cls_q == CLS_JAL) || (cls_q == CLS_JALR)) begin
                    wb_sel = WB_PC4;
                end else if (cls_q == CLS_LOAD) begin
                    wb_sel = WB_MEM;
                end else begin
                    wb_sel = WB_ALU;
                end
            end
            default: ;
        endcase
    end

    assign fault = fault_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] instret_cnt_q;
    logic        retire;

    assign retire = (state_d == S_IF) &&
                    ((state_q == S_EX) || (state_q == S_MEM) || (state_q == S_WB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            if ((state_q != S_RST) && (state_q != S_HALT)) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end
            if (retire) begin
                instret_cnt_q <= instret_cnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Cycle-accurate directed bench for multicycle_ctrl_fsm: per-cycle expected
// output vectors are queued by the stimulus and checked by a negedge monitor.
module tb_multicycle_ctrl_fsm;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       br_cond;
    logic       mem_ready;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write, fault;
    logic [1:0] pc_src, alu_src_a, alu_src_b, wb_sel;
    logic [3:0] alu_op;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(
        .MEM_TIMEOUT (16),
        .ALU_OP_W    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .br_cond     (br_cond),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .pc_src      (pc_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .wb_sel      (wb_sel),
        .fault       (fault)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic [1:0] ps;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] op;
        logic       mr;
        logic       mw;
        logic       rw;
        logic [1:0] wb;
        logic       f;
    } out_t;

    out_t  act;
    out_t  exp_q[$];
    string tag_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    assign act = {pc_write, ir_write, pc_src, alu_src_a, alu_src_b, alu_op,
                  mem_read, mem_write, reg_write, wb_sel, fault};

    function automatic out_t mk(input logic pcw, input logic irw, input logic [1:0] ps,
                                input logic [1:0] a, input logic [1:0] b, input logic [3:0] op,
                                input logic mr, input logic mw, input logic rw,
                                input logic [1:0] wb, input logic f);
        return {pcw, irw, ps, a, b, op, mr, mw, rw, wb, f};
    endfunction

    // Hand-written per-state vectors
    localparam out_t V_ZERO = 18'h0;
    localparam out_t V_HALT = 18'h1;
    out_t v_if, v_id, v_ld_mem, v_st_mem;

    out_t mon_exp;
    string mon_tag;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            vectors++;
            if (act !== mon_exp) begin
                miscompares++;
                $display("FAIL %s: got %05h want %05h (pcw irw ps a b op mr mw rw wb f)",
                         mon_tag, act, mon_exp);
            end
        end
    end

    task automatic cyc(input string tag, input out_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic load_instr(input string name, input logic [31:0] w);
        opcode = w[6:0];
        funct3 = w[14:12];
        funct7 = w[31:25];
        $display("instr %-12s word=%08h", name, w);
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        cyc({tag, "_rst"}, V_ZERO);
        rst_n = 1'b1;
        cyc({tag, "_rel"}, V_ZERO);
    endtask

    // IF, ID, EX, WB
    task automatic run4(input string name, input logic [31:0] w, input out_t ex, input out_t wb);
        load_instr(name, w);
        cyc({name, "_IF"}, v_if);
        cyc({name, "_ID"}, v_id);
        cyc({name, "_EX"}, ex);
        cyc({name, "_WB"}, wb);
    endtask

    initial begin
        v_if     = mk(1, 1, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0);
        v_id     = V_ZERO;
        v_ld_mem = mk(0, 0, 0, 0, 0, ALU_ADD, 1, 0, 0, 0, 0);
        v_st_mem = mk(0, 0, 0, 0, 0, ALU_ADD, 0, 1, 0, 0, 0);

        rst_n = 1'b0; br_cond = 1'b0; mem_ready = 1'b0;
        opcode = '0; funct3 = '0; funct7 = '0;
        @(posedge clk);
        #1;
        cyc("reset0", V_ZERO);
        cyc("reset1", V_ZERO);
        rst_n = 1'b1;
        cyc("rst_release", V_ZERO);

        run4("addi", 32'h00500093, mk(0, 0, 0, 0, 1, ALU_ADD, 0, 0, 0, 0, 0),
             mk(0, 0, 0, 0, 0, ALU_ADD, 0, 0, 1, 0, 0));
        run4("sub", 32'h402081B3, mk(0, 0, 0, 0, 0, ALU_SUB, 0, 0, 0, 0, 0),
             mk(0, 0, 0, 0, 0, ALU_ADD, 0, 0, 1, 0, 0));

        // beq taken / not taken: 3 cycles, straight back to IF
        br_cond = 1'b1;
        load_instr("beq_taken", 32'h00000463);
        cyc("beqT_IF", v_if);
        cyc("beqT_ID", v_id);
        cyc("beqT_EX", mk(1, 0, 2, 0, 0, ALU_SUB, 0, 0, 0, 0, 0));
        br_cond = 1'b0;
        load_instr("beq_nt", 32'h00000463);
        cyc("beqN_IF", v_if);
        cyc("beqN_ID", v_id);
        cyc("beqN_EX", mk(0, 0, 2, 0, 0, ALU_SUB, 0, 0, 0, 0, 0));

        run4("srai", 32'h4030D093, mk(0, 0, 0, 0, 1, ALU_SRA, 0, 0, 0, 0, 0),
             mk(0, 0, 0, 0, 0, ALU_ADD, 0, 0, 1, 0, 0));
        run4("lui", 32'h123450B7, mk(0, 0, 0, 2, 1, ALU_ADD, 0, 0, 0, 0, 0),
             mk(0, 0, 0, 0, 0, ALU_ADD, 0, 0, 1, 0, 0));
        run4("jal", 32'h008000EF, mk(1, 0, 2, 1, 1, ALU_ADD, 0, 0, 0, 0, 0),
             mk(0, 0, 0, 0, 0, ALU_ADD, 0, 0, 1, 2, 0));
        run4("jalr", 32'h00008067, mk(1, 0, 1, 0, 1, ALU_ADD, 0, 0, 0, 0, 0),
             mk(0, 0, 0, 0, 0, ALU_ADD, 0, 0, 1, 2, 0));

        // lw with mem_ready in the 4th MEM cycle
        load_instr("lw", 32'h0000A283);
        cyc("lw_IF", v_if);
        cyc("lw_ID", v_id);
        cyc("lw_EX", mk(0, 0, 0, 0, 1, ALU_ADD, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) cyc("lw_MEMwait", v_ld_mem);
        mem_ready = 1'b1;
        cyc("lw_MEMrdy", v_ld_mem);
        mem_ready = 1'b0;
        cyc("lw_WB", mk(0, 0, 0, 0, 0, ALU_ADD, 0, 0, 1, 1, 0));

        // sw completing exactly on the last allowed MEM cycle
        load_instr("sw_edge", 32'h0050A023);
        cyc("swE_IF", v_if);
        cyc("swE_ID", v_id);
        cyc("swE_EX", mk(0, 0, 0, 0, 1, ALU_ADD, 0, 0, 0, 0, 0));
        for (int i = 0; i < 15; i++) cyc("swE_MEMwait", v_st_mem);
        mem_ready = 1'b1;
        cyc("swE_MEM16rdy", v_st_mem);
        mem_ready = 1'b0;

        // sw that never gets ready: 16 MEM cycles then sticky halt
        load_instr("sw_tmo", 32'h0050A023);
        cyc("swT_IF", v_if);
        cyc("swT_ID", v_id);
        cyc("swT_EX", mk(0, 0, 0, 0, 1, ALU_ADD, 0, 0, 0, 0, 0));
        for (int i = 0; i < 16; i++) cyc("swT_MEMwait", v_st_mem);
        for (int i = 0; i < 3; i++) cyc("swT_HALT", V_HALT);
        pulse_reset("swT");

        load_instr("illegal0", 32'h00000000);
        cyc("ill0_IF", v_if);
        cyc("ill0_ID", v_id);
        cyc("ill0_HALT", V_HALT);
        cyc("ill0_HALT2", V_HALT);
        pulse_reset("ill0");

        load_instr("mul_ill", 32'h02208133);
        cyc("mul_IF", v_if);
        cyc("mul_ID", v_id);
        cyc("mul_HALT", V_HALT);
        pulse_reset("mul");

        // reset asserted mid-MEM: strobes must drop before the next clock edge
        load_instr("lw_rst", 32'h0000A283);
        cyc("lwR_IF", v_if);
        cyc("lwR_ID", v_id);
        cyc("lwR_EX", mk(0, 0, 0, 0, 1, ALU_ADD, 0, 0, 0, 0, 0));
        cyc("lwR_MEM1", v_ld_mem);
        cyc("lwR_MEM2", v_ld_mem);
        pulse_reset("lwR");
        run4("addi_after", 32'h00500093, mk(0, 0, 0, 0, 1, ALU_ADD, 0, 0, 0, 0, 0),
             mk(0, 0, 0, 0, 0, ALU_ADD, 0, 0, 1, 0, 0));

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want normal finish");
        $fatal(1, "watchdog");
    end

endmodule
